// File: rtl/ssd_display_scheduler.sv
// Round-robin arbiter that lends one 4-digit SSD controller to two requesters,
// keeping each granted value on the display for at least HOLD_CYCLES clocks.
module ssd_display_scheduler #(
  parameter int unsigned HOLD_CYCLES = 24'd10_000_000,
  parameter int unsigned CNT_W       = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [3:0]  mode0,
  input  logic [3:0]  mode1,
  input  logic        clr,
  output logic [1:0]  ack,
  output logic [3:0]  digit3,
  output logic [3:0]  digit2,
  output logic [3:0]  digit1,
  output logic [3:0]  digit0,
  output logic [3:0]  mode,
  output logic        owner,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_PARK = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      digits_q, digits_d;
  logic [3:0]       mode_q, mode_d;
  logic [1:0]       ack_q, ack_d;
  logic             owner_q, owner_d;

  logic grant_window;
  logic winner;

  // Hold expiry (count==0) reopens the arbiter on the same edge, so grants
  // are spaced exactly HOLD_CYCLES edges apart when requests are continuous.
  assign grant_window = (state_q != S_HOLD) || (count_q == '0);
  assign winner       = (&req) ? ~owner_q : req[1];

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    digits_d = digits_q;
    mode_d   = mode_q;
    owner_d  = owner_q;
    ack_d    = '0;

    if (clr) begin
      state_d = S_IDLE;
      mode_d  = '0;
    end else if (grant_window && (req != 2'b00)) begin
      state_d  = S_HOLD;
      count_d  = HOLD_LAST;
      owner_d  = winner;
      digits_d = winner ? data1 : data0;
      mode_d   = winner ? mode1 : mode0;
      ack_d    = winner ? 2'b10 : 2'b01;
    end else if (state_q == S_HOLD) begin
      if (count_q != '0) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        state_d = S_PARK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      digits_q <= '0;
      mode_q   <= '0;
      ack_q    <= '0;
      owner_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      digits_q <= digits_d;
      mode_q   <= mode_d;
      ack_q    <= ack_d;
      owner_q  <= owner_d;
    end
  end

  assign ack    = ack_q;
  assign digit3 = digits_q[15:12];
  assign digit2 = digits_q[11:8];
  assign digit1 = digits_q[7:4];
  assign digit0 = digits_q[3:0];
  assign mode   = mode_q;
  assign owner  = owner_q;
  assign busy   = (state_q == S_HOLD);

endmodule
